// File: rtl/track_select_ctrl.sv
// Track-index controller: multi-step PREV/NEXT with hold-off, direct load,
// and end-of-song auto-advance in wrap / stop-at-end / repeat-one / shuffle modes.
module track_select_ctrl #(
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned NUM_TRACKS = 8,
    parameter int unsigned STEP_W     = 3,
    parameter int unsigned HOLDOFF    = 500000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [STEP_W-1:0] PREV,
    input  logic [STEP_W-1:0] NEXT,
    input  logic              SONG_END,
    input  logic [1:0]        MODE,
    input  logic              LOAD_EN,
    input  logic [IDX_W-1:0]  LOAD_IDX,
    output logic [IDX_W-1:0]  SW,
    output logic              CHANGED,
    output logic              BUSY
);

    localparam int unsigned W     = IDX_W + STEP_W + 1;
    localparam int unsigned CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [W-1:0]     NT       = W'(NUM_TRACKS);
    localparam logic [W-1:0]     LAST     = W'(NUM_TRACKS - 1);
    localparam logic [15:0]      NT16     = 16'(NUM_TRACKS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] sw_q, sw_d;
    logic             changed_q, changed_d;
    logic [15:0]      lfsr_q;

    logic [W-1:0]  cur, step_raw, s, man_tgt, shuf_tgt, r;
    logic [15:0]   lfsr_mod;
    logic          prev_req, next_req;

    // Step arithmetic, all at W bits so cur + s never overflows.
    always_comb begin
        cur      = W'(sw_q);
        prev_req = (PREV != '0);
        next_req = (NEXT != '0);
        step_raw = prev_req ? W'(PREV) : W'(NEXT);
        s        = step_raw % NT;
        if (MODE == 2'b01) begin
            if (prev_req) man_tgt = (s > cur) ? '0 : cur - s;
            else          man_tgt = ((cur + s) > LAST) ? LAST : cur + s;
        end else begin
            if (prev_req) man_tgt = (cur + NT - s) % NT;
            else          man_tgt = (cur + s) % NT;
        end
        lfsr_mod = lfsr_q % NT16;
        r        = W'(lfsr_mod);
        shuf_tgt = (r == cur) ? (r + W'(1)) % NT : r;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sw_d      = sw_q;
        changed_d = 1'b0;

        if (state_q == StHold) begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - CNT_W'(1);
        end

        // An out-of-range load still claims the cycle, dropping lower-priority events.
        if (LOAD_EN) begin
            if (W'(LOAD_IDX) < NT) begin
                sw_d      = LOAD_IDX;
                changed_d = 1'b1;
            end
        end else if (state_q == StIdle && (prev_req || next_req)) begin
            sw_d      = IDX_W'(man_tgt);
            changed_d = (man_tgt != cur);
            if (HOLDOFF > 0) begin
                state_d = StHold;
                cnt_d   = CNT_LOAD;
            end
        end else if (SONG_END) begin
            unique case (MODE)
                2'b00: begin
                    sw_d      = IDX_W'((cur + W'(1)) % NT);
                    changed_d = 1'b1;
                end
                2'b01: begin
                    if (cur < LAST) begin
                        sw_d      = IDX_W'(cur + W'(1));
                        changed_d = 1'b1;
                    end
                end
                2'b10: changed_d = 1'b1;
                2'b11: begin
                    sw_d      = IDX_W'(shuf_tgt);
                    changed_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sw_q      <= '0;
            changed_q <= 1'b0;
            lfsr_q    <= 16'hACE1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sw_q      <= sw_d;
            changed_q <= changed_d;
            // Fibonacci taps 16,14,13,11
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign SW      = sw_q;
    assign CHANGED = changed_q;
    assign BUSY    = (state_q == StHold);

endmodule

// File: tb/tb_track_select_ctrl.sv
// Directed bench for track_select_ctrl: vector table plus hand-written
// sequences for hold-off timing, reset during hold, shuffle and a 6-track instance.
module tb_track_select_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] prev_s, next_s, load_idx;
    logic       song_end, load_en;
    logic [1:0] mode;
    logic [2:0] sw, sw6;
    logic       changed, busy, ch6, bz6;

    int n_cmp = 0;
    int n_err = 0;

    track_select_ctrl #(.IDX_W(3), .NUM_TRACKS(8), .STEP_W(3), .HOLDOFF(4)) dut (
        .CLK(clk), .RST(rst), .PREV(prev_s), .NEXT(next_s), .SONG_END(song_end),
        .MODE(mode), .LOAD_EN(load_en), .LOAD_IDX(load_idx),
        .SW(sw), .CHANGED(changed), .BUSY(busy)
    );

    track_select_ctrl #(.IDX_W(3), .NUM_TRACKS(6), .STEP_W(3), .HOLDOFF(0)) dut6 (
        .CLK(clk), .RST(rst), .PREV(prev_s), .NEXT(next_s), .SONG_END(song_end),
        .MODE(mode), .LOAD_EN(load_en), .LOAD_IDX(load_idx),
        .SW(sw6), .CHANGED(ch6), .BUSY(bz6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       le;
        logic [2:0] li;
        logic [2:0] pv;
        logic [2:0] nx;
        logic       se;
        logic [1:0] md;
        logic [2:0] sw;
        logic       ch;
        logic       bz;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(input logic le, input logic [2:0] li, input logic [2:0] pv,
                                input logic [2:0] nx, input logic se, input logic [1:0] md,
                                input logic [2:0] esw, input logic ech, input logic ebz);
        vec_t v;
        v.le = le; v.li = li; v.pv = pv; v.nx = nx; v.se = se; v.md = md;
        v.sw = esw; v.ch = ech; v.bz = ebz;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic quiet();
        prev_s = 0; next_s = 0; song_end = 0; load_en = 0; load_idx = 0; mode = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] last_sw;
    logic [7:0] hit;

    initial begin
        // le li pv nx se md | sw ch bz
        vecs[0]  = mk(1, 7, 0, 0, 0, 0, 7, 1, 0);
        vecs[1]  = mk(0, 0, 0, 3, 0, 0, 2, 1, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 2, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 2, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 2, 0, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 2, 0, 0);
        vecs[6]  = mk(1, 7, 0, 0, 0, 0, 7, 1, 0);
        vecs[7]  = mk(0, 0, 0, 3, 0, 1, 7, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 1, 1, 7, 0, 1);
        vecs[9]  = mk(1, 1, 0, 0, 0, 1, 1, 1, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 1, 0, 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[12] = mk(0, 0, 5, 0, 0, 1, 0, 1, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[17] = mk(1, 3, 0, 0, 0, 0, 3, 1, 0);
        vecs[18] = mk(0, 0, 0, 0, 1, 0, 4, 1, 0);
        vecs[19] = mk(1, 3, 0, 0, 0, 0, 3, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 1, 2, 3, 1, 0);
        vecs[21] = mk(1, 3, 1, 0, 0, 0, 3, 1, 0);
        vecs[22] = mk(0, 0, 2, 1, 0, 0, 1, 1, 1);
        vecs[23] = mk(1, 5, 0, 1, 0, 0, 5, 1, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 5, 0, 1);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 5, 0, 1);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 5, 0, 0);
        vecs[27] = mk(0, 0, 0, 0, 1, 1, 6, 1, 0);
        vecs[28] = mk(0, 0, 0, 0, 1, 1, 7, 1, 0);
        vecs[29] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[30] = mk(0, 0, 1, 0, 0, 0, 7, 1, 1);

        quiet();
        rst = 1'b1;
        tick();
        tick();
        check("reset_sw", sw, 0);
        check("reset_changed", changed, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;

        // Held NEXT with hold-off of 4: steps on cycles 1 and 6
        next_s = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("held_next_sw[%0d]", k), sw, (k >= 6) ? 2 : 1);
            check($sformatf("held_next_changed[%0d]", k), changed, (k == 1 || k == 6) ? 1 : 0);
            check($sformatf("held_next_busy[%0d]", k), busy, (k == 5 || k == 10) ? 0 : 1);
        end

        do_reset();
        for (int i = 0; i < 31; i++) begin
            load_en = vecs[i].le; load_idx = vecs[i].li; prev_s = vecs[i].pv;
            next_s = vecs[i].nx; song_end = vecs[i].se; mode = vecs[i].md;
            tick();
            check($sformatf("vec%0d_sw", i), sw, vecs[i].sw);
            check($sformatf("vec%0d_changed", i), changed, vecs[i].ch);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].bz);
        end

        // Reset in the middle of hold-off, with NEXT held throughout
        do_reset();
        load_en = 1; load_idx = 3;
        tick();
        load_en = 0; next_s = 1;
        tick();
        check("midhold_pre_sw", sw, 4);
        check("midhold_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("midhold_rst_sw", sw, 0);
        check("midhold_rst_busy", busy, 0);
        check("midhold_rst_changed", changed, 0);
        rst = 1'b0;
        tick();
        check("midhold_after_sw", sw, 1);
        check("midhold_after_changed", changed, 1);
        check("midhold_after_busy", busy, 1);

        // Shuffle: never repeats, every index reached
        do_reset();
        mode = 2'b11;
        last_sw = 0;
        hit = 8'h00;
        for (int i = 0; i < 200; i++) begin
            song_end = 1;
            tick();
            song_end = 0;
            check($sformatf("shuf_differs[%0d]", i), (sw != last_sw) ? 1 : 0, 1);
            check($sformatf("shuf_changed[%0d]", i), changed, 1);
            hit[sw] = 1'b1;
            last_sw = sw;
            tick();
        end
        check("shuf_all_hit", hit, 8'hFF);

        // 6-track instance without hold-off
        do_reset();
        load_en = 1; load_idx = 6; next_s = 1;
        tick();
        check("n6_load6_sw", sw6, 0);
        check("n6_load6_changed", ch6, 0);
        load_idx = 5; next_s = 0;
        tick();
        check("n6_load5_sw", sw6, 5);
        check("n6_load5_changed", ch6, 1);
        load_idx = 7; song_end = 1;
        tick();
        check("n6_load7_sw", sw6, 5);
        check("n6_load7_changed", ch6, 0);
        load_en = 0; song_end = 0; next_s = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("n6_held_sw[%0d]", k), sw6, k);
            check($sformatf("n6_held_changed[%0d]", k), ch6, 1);
            check($sformatf("n6_held_busy[%0d]", k), bz6, 0);
        end
        next_s = 0; prev_s = 3;
        tick();
        check("n6_prev3_sw", sw6, 5);
        prev_s = 0; next_s = 7; mode = 2'b01;
        tick();
        check("n6_clamp_sw", sw6, 5);
        check("n6_clamp_changed", ch6, 0);
        next_s = 0; mode = 2'b00; song_end = 1;
        tick();
        check("n6_wrap_end_sw", sw6, 0);
        check("n6_wrap_end_changed", ch6, 1);
        quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/track_select_ctrl.md
Name: track_select_ctrl

Overview:
- Parametrised track-index controller for the MP3 player. It is the successor to the fixed 3-bit prev/next selector.
- Accepts multi-step PREV/NEXT requests with a hold-off window, direct index loading, and auto-advance on end of song.
- Supports four play modes: wrap, stop-at-end, repeat-one, shuffle.
- Output index drives the song-address decoder and display.

Parameters:
IDX_W, 3, width of track index output
NUM_TRACKS, 8, number of valid tracks (2..2^IDX_W); valid indices 0..NUM_TRACKS-1
STEP_W, 3, width of PREV/NEXT step inputs
HOLDOFF, 500000, clock cycles manual PREV/NEXT is ignored after an accepted step (0 = no hold-off)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
PREV  input  STEP_W  step back by this amount; nonzero = request (level-sensitive)
NEXT  input  STEP_W  step forward by this amount; nonzero = request (level-sensitive)
SONG_END  input  1  one-cycle pulse from player at end of current song
MODE  input  2  00 wrap, 01 stop-at-end, 10 repeat-one, 11 shuffle
LOAD_EN  input  1  direct load strobe
LOAD_IDX  input  IDX_W  index to load
SW  output  IDX_W  current track index
CHANGED  output  1  one-cycle pulse: play (re)start of track SW
BUSY  output  1  high while hold-off counter running

Behaviour:
- Reset (RST=1 at rising edge) sets SW=0, CHANGED=0, BUSY=0, hold counter=0, LFSR=16'hACE1. Reset overrides every other input, including during hold-off.
- Two states:
  - IDLE: BUSY=0; manual PREV/NEXT accepted.
  - HOLD: BUSY=1; counter decrements each cycle; PREV/NEXT ignored.
  - HOLD->IDLE on the cycle the counter reaches 0.
- Accepted PREV/NEXT with HOLDOFF>0 loads counter=HOLDOFF-1 and enters HOLD. BUSY is high for exactly HOLDOFF cycles.
- With HOLDOFF=0 the block stays in IDLE, so a held request steps every cycle.
- A request held through HOLD is re-accepted on the first IDLE cycle (auto-repeat).
- Per-cycle priority: LOAD_EN > PREV > NEXT > SONG_END. Only one action per cycle; lower-priority events that cycle are dropped.
- LOAD_EN and SONG_END are accepted in both states. They neither start nor restart hold-off.
- Latency: SW updates and CHANGED pulses on the rising edge after the request is sampled (1 cycle). CHANGED=0 whenever no action changes or restarts the track.
- Step arithmetic uses s = step mod NUM_TRACKS, computed at IDX_W+STEP_W+1 bits with no intermediate overflow.
- Modes 00, 10, 11, manual steps: SW = (SW ± s) mod NUM_TRACKS.
- Mode 01, manual steps: clamp to 0..NUM_TRACKS-1. If the clamped result equals SW, SW is unchanged and CHANGED=0, but hold-off still starts.
- SONG_END by mode:
  - 00: SW = (SW+1) mod NUM_TRACKS.
  - 01: SW+1 if SW<NUM_TRACKS-1; at the last track SW holds and CHANGED=0.
  - 10: SW unchanged, CHANGED=1 (restart).
  - 11: r = LFSR mod NUM_TRACKS. If r==SW, use (r+1) mod NUM_TRACKS. Result is always different from SW.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle when not in reset, never all-zero.
- LOAD_EN with LOAD_IDX<NUM_TRACKS: SW=LOAD_IDX, CHANGED=1 even if equal to SW.
- LOAD_EN with LOAD_IDX>=NUM_TRACKS: ignored entirely. Lower-priority events that cycle are still dropped.
- PREV and NEXT both nonzero: PREV wins.
- MODE change takes effect on the next action; SW is unaffected by the change itself.

Test Plan:
- Reset, then NEXT=1 held for 10 cycles, HOLDOFF=4 -> SW steps 0->1->2 at accept cycles 1 and 6; BUSY high for 4 cycles after each step; one CHANGED pulse per step.
- MODE=00, SW=7, NEXT=3 -> SW=2. MODE=01, SW=7, NEXT=3 -> SW=7, CHANGED=0, BUSY=1. MODE=01, SW=1, PREV=5 -> SW=0.
- SONG_END with SW=3: MODE=00 -> 4. MODE=10 -> 3 with CHANGED=1. MODE=01 at SW=7 -> 7 with CHANGED=0.
- MODE=11, 200 SONG_END pulses -> SW always <NUM_TRACKS, never repeats the previous index, every index 0..7 is hit.
- LOAD_EN=1, LOAD_IDX=5, with NEXT=1 in the same cycle during HOLD -> SW=5, CHANGED=1, counter unaffected. NUM_TRACKS=6, LOAD_IDX=6 -> ignored.
- RST asserted mid-HOLD with SW=4 -> next cycle SW=0, BUSY=0; held NEXT is accepted the cycle after RST drops.
